// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI target.
// Holds the FSM state enum, default frame width and bit counter width.
package spi_pkg;

  localparam int SPI_DATA_W = 8;
  localparam int SPI_CNT_W  = $clog2(SPI_DATA_W);

  typedef enum logic [0:0] {
    IDLE,
    SHIFT
  } spi_state_t;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous pin.
// Emits the settled level plus 1-clk rise/fall strobes.
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_i};
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = level_o & ~prev_q;
  assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 target, MSB first, with one-deep tx buffer.
// Define SPI_SLAVE_UDR_EN to add the tx_udr_o underrun strobe.
module spi_slave
  import spi_pkg::*;
#(
  parameter int   DATA_W      = SPI_DATA_W,
  parameter int   SYNC_STAGES = 2,
  parameter logic IDLE_MISO   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SCLK,
  input  logic              CS,
  input  logic              MOSI,
  output logic              MISO,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  output logic              busy_o
`ifdef SPI_SLAVE_UDR_EN
  ,
  output logic              tx_udr_o
`endif
);

  localparam int CNT_W = $clog2(DATA_W);

  logic sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_lvl;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk(clk), .rst(rst), .d_i(SCLK),
    .level_o(), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clk(clk), .rst(rst), .d_i(CS),
    .level_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .clk(clk), .rst(rst), .d_i(MOSI),
    .level_o(mosi_lvl), .rise_o(), .fall_o()
  );

  spi_state_t        state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic              buf_full_q, buf_full_d;
  logic              miso_q, miso_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              done_q, done_d;
  logic              load;
  logic [DATA_W-1:0] load_byte;
`ifdef SPI_SLAVE_UDR_EN
  logic              udr_q, udr_d;
`endif

  // An empty buffer at load time sends the idle level as fill.
  assign load_byte = buf_full_q ? buf_q : {DATA_W{IDLE_MISO}};

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    miso_d     = miso_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = done_q;
    done_d     = 1'b0;
    load       = 1'b0;
    if (done_q) rx_data_d = rx_shift_q;
    unique case (state_q)
      IDLE: begin
        miso_d    = IDLE_MISO;
        bit_cnt_d = '0;
        if (cs_fall) begin
          state_d = SHIFT;
          load    = 1'b1;
        end
      end
      SHIFT: begin
        if (cs_rise | cs_lvl) begin
          state_d   = IDLE;
          miso_d    = IDLE_MISO;
          bit_cnt_d = '0;
        end else if (sclk_rise) begin
          rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_lvl};
          if (bit_cnt_q == CNT_W'(DATA_W-1)) begin
            bit_cnt_d = '0;
            done_d    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (sclk_fall) begin
          if (bit_cnt_q != '0) begin
            tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
            miso_d     = tx_shift_q[DATA_W-2];
          end else begin
            load = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      tx_shift_d = load_byte;
      miso_d     = load_byte[DATA_W-1];
      buf_full_d = 1'b0;
    end
    // Write lands after the load so a same-clk write stays buffered.
    if (tx_valid_i && !buf_full_q) begin
      buf_d      = tx_data_i;
      buf_full_d = 1'b1;
    end
  end

`ifdef SPI_SLAVE_UDR_EN
  assign udr_d = load & ~buf_full_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      miso_q     <= IDLE_MISO;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      done_q     <= 1'b0;
`ifdef SPI_SLAVE_UDR_EN
      udr_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      miso_q     <= miso_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      done_q     <= done_d;
`ifdef SPI_SLAVE_UDR_EN
      udr_q      <= udr_d;
`endif
    end
  end

  assign MISO       = miso_q;
  assign tx_ready_o = ~buf_full_q;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign busy_o     = (state_q == SHIFT);
`ifdef SPI_SLAVE_UDR_EN
  assign tx_udr_o   = udr_q;
`endif

endmodule
